// File: rtl/ysyx_24120013_exu_mc_if.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_exu_mc_if
// Handshake bundle between the multi-cycle execute unit and its neighbours.
//
// Upstream (operation issue):
//   in_valid  - an operation is presented
//   in_ready  - the execute unit can take it this cycle
//   in_op     - operation code
//   in_src1   - first operand
//   in_src2   - second operand (shift amount comes from its low bits)
//   in_imm    - immediate operand (ADDI)
//   in_rd     - destination register index
// Downstream (register write-back):
//   out_valid   - a result is held
//   out_ready   - write-back consumes the result this cycle
//   out_wen     - register write enable
//   out_waddr   - register write index
//   out_wdata   - register write data
//   out_illegal - the operation that produced this result was unsupported
//
// master: issuing/consuming side (pipeline or testbench)
// slave : the execute unit itself
// ---------------------------------------------------------------------------
interface ysyx_24120013_exu_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   in_op;
  logic [DATA_WIDTH-1:0] in_src1;
  logic [DATA_WIDTH-1:0] in_src2;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [ADDR_WIDTH-1:0] in_rd;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_wen;
  logic [ADDR_WIDTH-1:0] out_waddr;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_illegal;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_imm, in_rd, out_ready,
    input  in_ready, out_valid, out_wen, out_waddr, out_wdata, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_imm, in_rd, out_ready,
    output in_ready, out_valid, out_wen, out_waddr, out_wdata, out_illegal
  );
endinterface

// File: rtl/ysyx_24120013_exu_mc.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_exu_mc
// Single-issue execute unit. Simple ALU ops complete one cycle after they are
// accepted; MUL runs a shift-add loop, one multiplier bit per cycle, for
// DATA_WIDTH cycles. The result is held until write-back takes it.
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous, active-high reset; aborts any operation in flight
//   bus - ysyx_24120013_exu_mc_if.slave (issue + write-back handshakes)
//
// Op codes: 0 ADDI, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA,
//           9 SLT, 10 SLTU, 11 MUL, anything else is illegal.
// DATA_WIDTH must be a power of two, at least 8.
//
// States:
//   state  | meaning
//   S_IDLE | waiting for an operation, in_ready = 1
//   S_CALC | shift-add multiply in progress
//   S_DONE | result held, out_valid = 1 until out_ready
// ---------------------------------------------------------------------------
module ysyx_24120013_exu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_24120013_exu_mc_if.slave   bus
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int CNTW = SHW + 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DATA_WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(1);

  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(11);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  wen_q, wen_d;
  logic                  illegal_q, illegal_d;

  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_legal;
  logic                  is_mul;
  logic [DATA_WIDTH-1:0] acc_step;

  assign shamt = bus.in_src2[SHW-1:0];

  // Single-cycle result, evaluated straight off the inputs so it can be
  // captured at the accepting edge. MUL only flags itself here.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    is_mul    = 1'b0;
    case (bus.in_op)
      OP_ADDI: alu_res = bus.in_src1 + bus.in_imm;
      OP_ADD:  alu_res = bus.in_src1 + bus.in_src2;
      OP_SUB:  alu_res = bus.in_src1 - bus.in_src2;
      OP_AND:  alu_res = bus.in_src1 & bus.in_src2;
      OP_OR:   alu_res = bus.in_src1 | bus.in_src2;
      OP_XOR:  alu_res = bus.in_src1 ^ bus.in_src2;
      OP_SLL:  alu_res = bus.in_src1 << shamt;
      OP_SRL:  alu_res = bus.in_src1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.in_src1) >>> shamt);
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}},
                          ($signed(bus.in_src1) < $signed(bus.in_src2))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (bus.in_src1 < bus.in_src2)};
      OP_MUL:  is_mul  = 1'b1;
      default: alu_legal = 1'b0;
    endcase
  end

  // One multiply step: add the multiplicand when the current multiplier LSB
  // is set. The multiplicand shifts left and the multiplier right each cycle,
  // so only the low DATA_WIDTH product bits are ever formed.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    wen_d     = wen_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          waddr_d   = bus.in_rd;
          illegal_d = ~alu_legal;
          wen_d     = alu_legal && (bus.in_rd != '0);
          wdata_d   = alu_res;
          if (is_mul) begin
            mcand_d  = bus.in_src1;
            mplier_d = bus.in_src2;
            acc_d    = '0;
            cnt_d    = CNT_LOAD;
            state_d  = S_CALC;
          end else begin
            state_d  = S_DONE;
          end
        end
      end

      S_CALC: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_LAST;
        // Terminal count: this edge performs the last of DATA_WIDTH steps.
        if (cnt_q == CNT_LAST) begin
          wdata_d = acc_step;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      wen_q     <= wen_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.out_wen     = wen_q;
  assign bus.out_waddr   = waddr_q;
  assign bus.out_wdata   = wdata_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_ysyx_24120013_exu_mc.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24120013_exu_mc
// Drives operations through the issue handshake, pushes the expected result
// for each into a queue, and a negedge monitor pops and compares whenever the
// write-back handshake completes (data, flags, index, latency, hold length).
// ---------------------------------------------------------------------------
module tb_ysyx_24120013_exu_mc;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        wen;
    logic        ill;
    logic [4:0]  waddr;
    int          lat;
    int          vcyc;
  } exp_t;

  logic clk;
  logic rst;

  ysyx_24120013_exu_mc_if bus ();

  ysyx_24120013_exu_mc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  int   ncyc    = 0;
  int   acc_cyc = 0;
  int   vcount  = 0;
  int   lat_seen = 0;
  bit   busy    = 1'b0;
  logic [31:0] hold_data;
  logic        hold_wen;
  logic        hold_ill;
  logic [4:0]  hold_waddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Write-back monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    if (rst) begin
      busy   = 1'b0;
      vcount = 0;
    end else begin
      if (busy) check("in_ready_while_busy", 64'(bus.in_ready), 64'(0));
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc = ncyc;
        busy    = 1'b1;
      end
      if (bus.out_valid) begin
        if (vcount == 0) begin
          lat_seen   = ncyc - acc_cyc;
          hold_data  = bus.out_wdata;
          hold_wen   = bus.out_wen;
          hold_ill   = bus.out_illegal;
          hold_waddr = bus.out_waddr;
        end else begin
          check("hold_wdata",   64'(bus.out_wdata),   64'(hold_data));
          check("hold_wen",     64'(bus.out_wen),     64'(hold_wen));
          check("hold_illegal", 64'(bus.out_illegal), 64'(hold_ill));
          check("hold_waddr",   64'(bus.out_waddr),   64'(hold_waddr));
        end
        vcount = vcount + 1;
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got wdata %0h with no operation pending", bus.out_wdata);
          end else begin
            e = sb.pop_front();
            check("wdata",       64'(bus.out_wdata),   64'(e.data));
            check("wen",         64'(bus.out_wen),     64'(e.wen));
            check("illegal",     64'(bus.out_illegal), 64'(e.ill));
            check("waddr",       64'(bus.out_waddr),   64'(e.waddr));
            check("latency",     64'(lat_seen),        64'(e.lat));
            check("valid_cycles", 64'(vcount),         64'(e.vcyc));
          end
          vcount = 0;
          busy   = 1'b0;
        end
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] data,
                              input logic wen, input logic ill);
    vec_t v;
    v.op = op; v.s1 = s1; v.s2 = s2; v.imm = imm; v.rd = rd;
    v.data = data; v.wen = wen; v.ill = ill;
    return v;
  endfunction

  // Reference behaviour for the random vectors.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [4:0]  sh;
    logic [63:0] p;
    r   = v;
    sh  = v.s2[4:0];
    r.ill = 1'b0;
    case (v.op)
      4'd0:  r.data = v.s1 + v.imm;
      4'd1:  r.data = v.s1 + v.s2;
      4'd2:  r.data = v.s1 - v.s2;
      4'd3:  r.data = v.s1 & v.s2;
      4'd4:  r.data = v.s1 | v.s2;
      4'd5:  r.data = v.s1 ^ v.s2;
      4'd6:  r.data = v.s1 << sh;
      4'd7:  r.data = v.s1 >> sh;
      4'd8:  r.data = $unsigned($signed(v.s1) >>> sh);
      4'd9:  r.data = ($signed(v.s1) < $signed(v.s2)) ? 32'd1 : 32'd0;
      4'd10: r.data = (v.s1 < v.s2) ? 32'd1 : 32'd0;
      4'd11: begin
        p = 64'(v.s1) * 64'(v.s2);
        r.data = p[31:0];
      end
      default: begin
        r.data = 32'd0;
        r.ill  = 1'b1;
      end
    endcase
    r.wen = !r.ill && (v.rd != 5'd0);
    return r;
  endfunction

  task automatic send(input vec_t v, input bit expect_out, input int vcyc);
    int   g;
    exp_t e;
    g = 0;
    while (!bus.in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready still %0b after %0d cycles", bus.in_ready, g);
      return;
    end
    if (expect_out) begin
      e.data  = v.data;
      e.wen   = v.wen;
      e.ill   = v.ill;
      e.waddr = v.rd;
      e.lat   = (v.op == 4'd11) ? 33 : 1;
      e.vcyc  = vcyc;
      sb.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_src1  = v.s1;
    bus.in_src2  = v.s2;
    bus.in_imm   = v.imm;
    bus.in_rd    = v.rd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 4'($urandom);
    bus.in_src1  = $urandom;
    bus.in_src2  = $urandom;
    bus.in_imm   = $urandom;
    bus.in_rd    = 5'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || busy) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;

    vecs.push_back(mk(4'd0,  32'h0000_0010, 32'h0000_DEAD, 32'hFFFF_FFF0, 5'd3,  32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd1,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0,         5'd1,  32'h0000_0001, 1'b1, 1'b0));
    vecs.push_back(mk(4'd2,  32'h0000_0005, 32'h0000_0007, 32'h0,         5'd2,  32'hFFFF_FFFE, 1'b1, 1'b0));
    vecs.push_back(mk(4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         5'd6,  32'hF000_F000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd4,  32'hF0F0_F0F0, 32'h0F00_FF00, 32'h0,         5'd7,  32'hFFF0_FFF0, 1'b1, 1'b0));
    vecs.push_back(mk(4'd5,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,         5'd8,  32'hF0F0_0F0F, 1'b1, 1'b0));
    vecs.push_back(mk(4'd6,  32'h0000_0001, 32'h0000_0024, 32'h0,         5'd10, 32'h0000_0010, 1'b1, 1'b0));
    vecs.push_back(mk(4'd6,  32'h0000_0003, 32'hFFFF_FFFF, 32'h0,         5'd22, 32'h8000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd7,  32'h8000_0000, 32'h0000_0024, 32'h0,         5'd11, 32'h0800_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd8,  32'h8000_0000, 32'h0000_0024, 32'h0,         5'd12, 32'hF800_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd8,  32'h8000_0000, 32'h0000_0020, 32'h0,         5'd13, 32'h8000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd8,  32'h4000_0000, 32'h0000_001F, 32'h0,         5'd14, 32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         5'd15, 32'h0000_0001, 1'b1, 1'b0));
    vecs.push_back(mk(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         5'd16, 32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         5'd17, 32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd10, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         5'd18, 32'h0000_0001, 1'b1, 1'b0));
    vecs.push_back(mk(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         5'd5,  32'h0000_0001, 1'b1, 1'b0));
    vecs.push_back(mk(4'd11, 32'h0001_0000, 32'h0001_0001, 32'h0,         5'd19, 32'h0001_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd11, 32'h0000_0007, 32'h0000_0006, 32'h0,         5'd0,  32'h0000_002A, 1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,         5'd20, 32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd11, 32'h8000_0000, 32'h0000_0003, 32'h0,         5'd21, 32'h8000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(4'd14, 32'h0000_0123, 32'h0000_0456, 32'h0,         5'd9,  32'h0000_0000, 1'b0, 1'b1));
    vecs.push_back(mk(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         5'd1,  32'h0000_0000, 1'b0, 1'b1));
    vecs.push_back(mk(4'd15, 32'h1234_5678, 32'h0000_0001, 32'h0,         5'd0,  32'h0000_0000, 1'b0, 1'b1));
    vecs.push_back(mk(4'd0,  32'h0000_0005, 32'h0,         32'h0000_0006, 5'd0,  32'h0000_000B, 1'b0, 1'b0));

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_imm    = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b1;

    #7;
    check("rst_in_ready",    64'(bus.in_ready),    64'(1));
    check("rst_out_valid",   64'(bus.out_valid),   64'(0));
    check("rst_out_wen",     64'(bus.out_wen),     64'(0));
    check("rst_out_illegal", 64'(bus.out_illegal), 64'(0));
    check("rst_out_waddr",   64'(bus.out_waddr),   64'(0));
    check("rst_out_wdata",   64'(bus.out_wdata),   64'(0));

    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i], 1'b1, 1);
    end
    drain();

    // Backpressure: ADD 7+9 to rd 0 held for four stalled cycles, with a
    // competing request waved at the input the whole time.
    bus.out_ready = 1'b0;
    send(mk(4'd1, 32'd7, 32'd9, 32'd0, 5'd0, 32'd16, 1'b0, 1'b0), 1'b1, 5);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'd2;
    bus.in_src1  = 32'h0000_1000;
    bus.in_src2  = 32'h0000_0001;
    bus.in_rd    = 5'd7;
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of a multiply: nothing may come out for it.
    send(mk(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd5, 32'd1, 1'b1, 1'b0), 1'b0, 1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    #2;
    check("mul_busy_before_abort", 64'(bus.in_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("abort_in_ready",    64'(bus.in_ready),  64'(1));
    check("abort_out_valid",   64'(bus.out_valid), 64'(0));
    check("abort_out_wen",     64'(bus.out_wen),   64'(0));
    check("abort_out_waddr",   64'(bus.out_waddr), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready_after_rst", 64'(bus.in_ready), 64'(1));
    repeat (40) begin
      @(posedge clk); #1;
    end
    send(mk(4'd1, 32'd1, 32'd1, 32'd0, 5'd4, 32'd2, 1'b1, 1'b0), 1'b1, 1);
    drain();

    for (int i = 0; i < 24; i++) begin
      v.op  = 4'($urandom_range(0, 15));
      v.s1  = $urandom;
      v.s2  = $urandom;
      v.imm = $urandom;
      v.rd  = 5'($urandom);
      v     = model(v);
      send(v, 1'b1, 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
